// File: rtl/periph_rx_arbiter.sv
// Round-robin arbiter that bursts packets from periph RX FIFOs into a 2-entry
// output buffer toward the USB transmit path; almost-full FIFOs win first.
module periph_rx_arbiter #(
   parameter int unsigned NUM_PERIPHS  = 4,
   parameter int unsigned PACKET_WIDTH = 32,
   parameter int unsigned MAX_BURST    = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_PERIPHS*PACKET_WIDTH-1:0]   periph_rx_data_i,
   input  logic [NUM_PERIPHS-1:0]                periph_rx_empty_i,
   input  logic [NUM_PERIPHS-1:0]                periph_rx_almost_full_i,
   input  logic [NUM_PERIPHS-1:0]                periph_ready_i,
   output logic [NUM_PERIPHS-1:0]                periph_rx_read_o,
   output logic [PACKET_WIDTH-1:0]               usb_data_o,
   output logic                                  usb_valid_o,
   input  logic                                  usb_ready_i,
   output logic [NUM_PERIPHS-1:0]                grant_o,
   output logic                                  busy_o
);

   localparam int unsigned IDX_W = $clog2(NUM_PERIPHS);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_e;

   state_e                  state_q, state_d;
   logic [NUM_PERIPHS-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]        rr_q, rr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    inflight_q;
   logic                    v0_q, v0_d, v1_q, v1_d;
   logic [PACKET_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;

   logic [NUM_PERIPHS-1:0]  eligible, urgent, req, rd_c;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_vld;
   logic                    pop, slot_ok;
   logic [1:0]              used;
   logic [PACKET_WIDTH-1:0] rx_slice [NUM_PERIPHS];
   logic [PACKET_WIDTH-1:0] rx_data;

   for (genvar i = 0; i < NUM_PERIPHS; i++) begin : g_slice
      assign rx_slice[i] = periph_rx_data_i[i*PACKET_WIDTH +: PACKET_WIDTH];
   end

   assign eligible = periph_ready_i & ~periph_rx_empty_i;
   assign urgent   = eligible & periph_rx_almost_full_i;
   assign rx_data  = rx_slice[rr_q];

   // First requester after the rr pointer; urgent set masks the eligible set.
   always_comb begin
      int idx;
      req      = (|urgent) ? urgent : eligible;
      pick_vld = |req;
      pick_idx = '0;
      for (int k = int'(NUM_PERIPHS); k >= 1; k--) begin
         idx = (int'(rr_q) + k) % int'(NUM_PERIPHS);
         if (req[IDX_W'(idx)]) pick_idx = IDX_W'(idx);
      end
   end

   // A read may be issued if its data will find a free slot one cycle later.
   assign pop     = v0_q & usb_ready_i;
   assign used    = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q);
   assign slot_ok = (used < 2'd2) | pop;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      rd_c    = '0;
      unique case (state_q)
         IDLE: if (|eligible) state_d = GRANT;
         GRANT: begin
            if (pick_vld) begin
               grant_d = NUM_PERIPHS'(1) << pick_idx;
               rr_d    = pick_idx;
               cnt_d   = '0;
               state_d = BURST;
            end else begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         BURST: begin
            if (periph_rx_empty_i[rr_q] || !periph_ready_i[rr_q]) begin
               state_d = DRAIN;
            end else if (slot_ok) begin
               rd_c[rr_q] = 1'b1;
               cnt_d      = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MAX_BURST - 1)) state_d = DRAIN;
            end
         end
         DRAIN: if (!inflight_q) state_d = GRANT;
         default: state_d = IDLE;
      endcase
   end

   // Output buffer: pop shifts entry 1 to head, push fills first free slot.
   always_comb begin
      v0_d = v0_q;
      v1_d = v1_q;
      d0_d = d0_q;
      d1_d = d1_q;
      if (pop) begin
         v0_d = v1_q;
         d0_d = d1_q;
         v1_d = 1'b0;
      end
      if (inflight_q) begin
         if (!v0_d) begin
            v0_d = 1'b1;
            d0_d = rx_data;
         end else begin
            v1_d = 1'b1;
            d1_d = rx_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_q       <= IDX_W'(NUM_PERIPHS - 1);
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         d0_q       <= '0;
         d1_q       <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         inflight_q <= |rd_c;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         d0_q       <= d0_d;
         d1_q       <= d1_d;
      end
   end

   assign periph_rx_read_o = rd_c;
   assign usb_data_o       = d0_q;
   assign usb_valid_o      = v0_q;
   assign grant_o          = grant_q;
   assign busy_o           = (state_q != IDLE) | v0_q | v1_q;

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// Bench for periph_rx_arbiter: FIFO models, scoreboard, arbitration model,
// directed scenarios and a randomized soak.
module tb_periph_rx_arbiter;

   localparam int unsigned NP    = 4;
   localparam int unsigned PW    = 32;
   localparam int unsigned MB    = 16;
   localparam int unsigned DEPTH = 1024;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NP*PW-1:0] rx_data;
   logic [NP-1:0]  fifo_empty, af, pready, rd, grant;
   logic [PW-1:0]  usb_data;
   logic           usb_valid, usb_ready, busy;

   periph_rx_arbiter #(.NUM_PERIPHS(NP), .PACKET_WIDTH(PW), .MAX_BURST(MB)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .periph_rx_data_i        (rx_data),
      .periph_rx_empty_i       (fifo_empty),
      .periph_rx_almost_full_i (af),
      .periph_ready_i          (pready),
      .periph_rx_read_o        (rd),
      .usb_data_o              (usb_data),
      .usb_valid_o             (usb_valid),
      .usb_ready_i             (usb_ready),
      .grant_o                 (grant),
      .busy_o                  (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // ---------------- FIFO models (standard read mode, 1-cycle latency) ----
   logic [PW-1:0] mem  [NP][DEPTH];
   int            wp   [NP] = '{default: 0};
   int            rp   [NP] = '{default: 0};
   int            seq  [NP] = '{default: 0};
   logic [PW-1:0] dout [NP] = '{default: '0};
   logic [PW-1:0] readq[NP][$];

   always_comb for (int i = 0; i < NP; i++) fifo_empty[i] = (rp[i] == wp[i]);
   always_comb for (int i = 0; i < NP; i++) rx_data[i*PW +: PW] = dout[i];

   always @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (rd[i] && rp[i] != wp[i]) begin
            dout[i] <= mem[i][rp[i]];
            readq[i].push_back(mem[i][rp[i]]);
            rp[i]   <= rp[i] + 1;
         end
      end
   end

   task automatic push_pkts(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         mem[p][wp[p]] = {4'(p), 28'(seq[p])};
         seq[p]++;
         wp[p]++;
      end
   endtask

   // ---------------- monitor: legality, arbitration model, scoreboard ------
   typedef struct { int cyc; int idx; } rd_ev_t;
   rd_ev_t        rd_log[$];
   logic [NP-1:0] grant_log[$];
   int            usb_log[$];
   int            cyc = 0;

   logic [NP-1:0] elig_p, urg_p, prev_grant;
   int            rr_model = NP - 1;
   logic          hold_p = 1'b0;
   logic [PW-1:0] hold_data;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rr_pick(input int last, input logic [NP-1:0] req);
      int res = -1;
      for (int k = 1; k <= NP; k++)
         if (res < 0 && req[(last + k) % NP]) res = (last + k) % NP;
      return res;
   endfunction

   always @(negedge clk) begin
      logic [NP-1:0] elig, urg;
      int            exp_w, p;
      if (!rst_n) begin
         for (int i = 0; i < NP; i++) readq[i].delete();
         rr_model   = NP - 1;
         prev_grant = '0;
         elig_p     = '0;
         urg_p      = '0;
         hold_p     = 1'b0;
      end else begin
         elig = pready & ~fifo_empty;
         urg  = elig & af;
         if (rd != '0) begin
            check_eq("rd_legal", 64'(rd & ~elig), 64'(0));
            check_eq("rd_granted", 64'(rd & ~grant), 64'(0));
            for (int i = 0; i < NP; i++) if (rd[i]) rd_log.push_back('{cyc, i});
         end
         if (grant != prev_grant && grant != '0) begin
            exp_w = rr_pick(rr_model, (urg_p != '0) ? urg_p : elig_p);
            check_eq("grant_pick", 64'(grant), (exp_w < 0) ? 64'(0) : 64'(1) << exp_w);
            for (int i = 0; i < NP; i++) if (grant[i]) rr_model = i;
            grant_log.push_back(grant);
         end
         prev_grant = grant;
         elig_p     = elig;
         urg_p      = urg;
         if (hold_p) begin
            check_eq("usb_hold_valid", 64'(usb_valid), 64'(1));
            check_eq("usb_hold_data", 64'(usb_data), 64'(hold_data));
         end
         hold_p    = usb_valid && !usb_ready;
         hold_data = usb_data;
         if (usb_valid && usb_ready) begin
            p = int'(usb_data[PW-1 -: 4]);
            usb_log.push_back(cyc);
            if (p >= NP || readq[p].size() == 0) check_eq("usb_unexpected", 64'(usb_data), 64'(0));
            else check_eq("usb_order", 64'(usb_data), 64'(readq[p].pop_front()));
         end
      end
   end

   // ---------------- helpers ----------------
   int s_idx[$], s_len[$], s_first[$], s_last[$];

   task automatic build_sessions();
      s_idx.delete(); s_len.delete(); s_first.delete(); s_last.delete();
      foreach (rd_log[k]) begin
         if (s_idx.size() == 0 || rd_log[k].idx != s_idx[s_idx.size()-1]) begin
            s_idx.push_back(rd_log[k].idx);
            s_len.push_back(1);
            s_first.push_back(rd_log[k].cyc);
            s_last.push_back(rd_log[k].cyc);
         end else begin
            s_len[s_len.size()-1]++;
            s_last[s_last.size()-1] = rd_log[k].cyc;
         end
      end
   endtask

   task automatic clear_logs();
      rd_log.delete(); grant_log.delete(); usb_log.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check_eq("rst_rd", 64'(rd), 64'(0));
      check_eq("rst_valid", 64'(usb_valid), 64'(0));
      check_eq("rst_grant", 64'(grant), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int quiet = 0, n = 0;
      while (quiet < 3 && n < budget) begin
         @(negedge clk);
         n++;
         if (&fifo_empty && !busy && !usb_valid) quiet++; else quiet = 0;
      end
      check_eq({tag, "_idle"}, 64'(quiet >= 3), 64'(1));
      for (int p = 0; p < NP; p++) check_eq({tag, "_lost"}, 64'(readq[p].size()), 64'(0));
   endtask

   task automatic wait_reads(input string tag, input int n_rd);
      int n = 0;
      while (rd_log.size() < n_rd && n < 200) begin @(negedge clk); n++; end
      check_eq({tag, "_start"}, 64'(rd_log.size() >= n_rd), 64'(1));
   endtask

   // ---------------- stimulus ----------------
   int exp_idx[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_len[8] = '{16, 16, 16, 16, 4, 4, 4, 4};

   initial begin
      int w0, cnt;
      rst_n = 1'b0; af = '0; pready = '0; usb_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_grant", 64'(grant), 64'(0));
      check_eq("reset_valid", 64'(usb_valid), 64'(0));
      check_eq("reset_busy", 64'(busy), 64'(0));
      check_eq("reset_data", 64'(usb_data), 64'(0));
      check_eq("reset_rd", 64'(rd), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      pready = '1; usb_ready = 1'b1;

      // single periph, short burst
      clear_logs();
      push_pkts(1, 3);
      wait_idle("t1", 200);
      check_eq("t1_grants", 64'(grant_log.size()), 64'(1));
      if (grant_log.size() > 0) check_eq("t1_grant", 64'(grant_log[0]), 64'(4'b0010));
      check_eq("t1_reads", 64'(rd_log.size()), 64'(3));
      if (rd_log.size() == 3) check_eq("t1_rd_span", 64'(rd_log[2].cyc - rd_log[0].cyc), 64'(2));
      check_eq("t1_usb", 64'(usb_log.size()), 64'(3));
      if (usb_log.size() == 3) check_eq("t1_usb_span", 64'(usb_log[2] - usb_log[0]), 64'(2));
      check_eq("t1_busy", 64'(busy), 64'(0));

      // round robin with MAX_BURST limit
      do_reset();
      for (int p = 0; p < NP; p++) push_pkts(p, 20);
      wait_idle("t2", 1000);
      build_sessions();
      check_eq("t2_sessions", 64'(s_idx.size()), 64'(8));
      for (int k = 0; k < 8 && k < s_idx.size(); k++) begin
         check_eq("t2_idx", 64'(s_idx[k]), 64'(exp_idx[k]));
         check_eq("t2_len", 64'(s_len[k]), 64'(exp_len[k]));
      end
      if (s_idx.size() > 0) check_eq("t2_rate", 64'(s_last[0] - s_first[0]), 64'(MB - 1));

      // urgent request waits for running burst, then jumps ahead
      do_reset();
      push_pkts(0, 10); push_pkts(2, 10); push_pkts(3, 10);
      wait_reads("t3", 3);
      af[3] = 1'b1;
      wait_idle("t3", 1000);
      af = '0;
      build_sessions();
      check_eq("t3_sessions", 64'(s_idx.size()), 64'(3));
      if (s_idx.size() == 3) begin
         check_eq("t3_first", 64'(s_idx[0]), 64'(0));
         check_eq("t3_first_len", 64'(s_len[0]), 64'(10));
         check_eq("t3_urgent", 64'(s_idx[1]), 64'(3));
         check_eq("t3_last", 64'(s_idx[2]), 64'(2));
      end

      // downstream stall
      do_reset();
      push_pkts(1, 12);
      wait_reads("t4", 2);
      @(posedge clk); #1 usb_ready = 1'b0;
      w0 = cyc;
      repeat (10) @(posedge clk);
      #1 usb_ready = 1'b1;
      cnt = 0;
      foreach (rd_log[k]) if (rd_log[k].cyc >= w0 && rd_log[k].cyc < w0 + 10) cnt++;
      check_eq("t4_stall_reads", 64'(cnt <= 2), 64'(1));
      wait_idle("t4", 500);
      check_eq("t4_reads", 64'(rd_log.size()), 64'(12));
      check_eq("t4_usb", 64'(usb_log.size()), 64'(12));

      // not-ready periph is never touched
      do_reset();
      pready = 4'b1011;
      push_pkts(2, 5); push_pkts(0, 3);
      repeat (40) @(negedge clk);
      cnt = 0;
      foreach (rd_log[k]) if (rd_log[k].idx == 2) cnt++;
      foreach (grant_log[k]) if (grant_log[k][2]) cnt++;
      check_eq("t5_blocked", 64'(cnt), 64'(0));
      pready = '1;
      wait_idle("t5", 500);
      cnt = 0;
      foreach (rd_log[k]) if (rd_log[k].idx == 2) cnt++;
      check_eq("t5_served", 64'(cnt), 64'(5));

      // async reset mid-burst, arbitration restarts at periph 0
      do_reset();
      push_pkts(0, 10); push_pkts(1, 10);
      wait_reads("t6", 3);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check_eq("t6_rd", 64'(rd), 64'(0));
      check_eq("t6_valid", 64'(usb_valid), 64'(0));
      check_eq("t6_grant", 64'(grant), 64'(0));
      check_eq("t6_busy", 64'(busy), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      clear_logs();
      wait_idle("t6", 500);
      check_eq("t6_grants", 64'(grant_log.size() > 0), 64'(1));
      if (grant_log.size() > 0) check_eq("t6_restart", 64'(grant_log[0]), 64'(4'b0001));

      // randomized soak
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int p;
         @(posedge clk); #1;
         usb_ready = ($urandom_range(3) != 0);
         if ($urandom_range(49) == 0) begin
            p = int'($urandom_range(NP - 1));
            pready[p] = ~pready[p];
         end
         if ($urandom_range(19) == 0) af = NP'($urandom);
         if ($urandom_range(5) == 0) begin
            p = int'($urandom_range(NP - 1));
            if (wp[p] < DEPTH - 8) push_pkts(p, int'($urandom_range(1, 4)));
         end
      end
      pready = '1; af = '0; usb_ready = 1'b1;
      wait_idle("t7", 3000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
